// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2 convolutional encoder and the Viterbi
// decoder: generator masks per constraint length, FSM state type and the
// symbol packing layout of the byte interface.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    PAD  = 2'd3
  } state_t;

  // Symbol layout: two bits per symbol, four symbols per byte, oldest symbol
  // in the least significant position.
  localparam int         SYM_W         = 2;
  localparam int         SYMS_PER_BYTE = 4;
  localparam int         PACK_W        = SYM_W * (SYMS_PER_BYTE - 1);
  localparam int         SYM_G0_BIT    = 1;
  localparam int         SYM_G1_BIT    = 0;
  localparam logic [1:0] PAD_SYM       = 2'b00;
  localparam int         K_MAX         = 7;

  // Generator G0, bit j taps the input bit j steps in the past.
  function automatic logic [K_MAX-1:0] gen_g0(input int k);
    case (k)
      3:       return 7'b0000111;
      5:       return 7'b0010011;
      7:       return 7'b1111001;
      default: return '0;
    endcase
  endfunction

  // Generator G1, same tap convention as G0.
  function automatic logic [K_MAX-1:0] gen_g1(input int k);
    case (k)
      3:       return 7'b0000101;
      5:       return 7'b0011101;
      7:       return 7'b1011011;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder register: K-1 bits of history plus the combinational
// two-bit symbol for the bit currently presented on bit_in.
module conv_enc_core
  import viterbi_pkg::*;
#(
  parameter int K = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic             bit_in,
  output logic [SYM_W-1:0] sym_out
);
  localparam logic [K_MAX-1:0] G0_ALL = gen_g0(K);
  localparam logic [K_MAX-1:0] G1_ALL = gen_g1(K);
  localparam logic [K-1:0]     G0     = G0_ALL[K-1:0];
  localparam logic [K-1:0]     G1     = G1_ALL[K-1:0];

  logic [K-2:0] st;
  logic [K-1:0] r;

  // Newest bit sits in the LSB so the generator masks tap history by bit index.
  always_comb begin
    r                   = {st, bit_in};
    sym_out             = '0;
    sym_out[SYM_G0_BIT] = ^(r & G0);
    sym_out[SYM_G1_BIT] = ^(r & G1);
  end

  // History register: cleared at frame start, shifts once per encoded bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      st <= '0;
    else if (clr) st <= '0;
    else if (adv) st <= {st[K-3:0], bit_in};
  end

endmodule

// File: rtl/conv_encoder_packer.sv
// Rate-1/2 convolutional encoder feeding a 4-symbol byte packer. Bytes enter
// LSB first; frames flagged eof optionally get K-1 zero tail bits and zero
// padding up to a whole symbol byte.
module conv_encoder_packer
  import viterbi_pkg::*;
#(
  parameter int K       = 5,
  parameter bit TAIL_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_eof,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);
  if (!(K == 3 || K == 5 || K == 7)) begin : g_bad_k
    $error("conv_encoder_packer: K must be 3, 5 or 7");
  end

  localparam logic [2:0] TAIL_LAST = 3'(K - 2);
  localparam logic [1:0] SYM_LAST  = 2'(SYMS_PER_BYTE - 1);

  state_t            state, state_nxt;
  logic [7:0]        shreg;
  logic [2:0]        bit_cnt;
  logic              eof_q;
  logic [1:0]        sym_cnt;
  logic [PACK_W-1:0] pack;
  logic [SYM_W-1:0]  core_sym, sym;
  logic              accept, encoding, active, byte_done, blocked, adv;
  logic              last_step, frame_end, enc_bit;

  // Step control: a step only stalls when it would load a full output
  // register that is not draining on the same edge.
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    encoding  = (state == DATA) || (state == TAIL);
    active    = encoding || (state == PAD);
    byte_done = (sym_cnt == SYM_LAST);
    blocked   = byte_done && out_valid && !out_ready;
    adv       = active && !blocked;
    enc_bit   = (state == DATA) ? shreg[0] : 1'b0;
    sym       = (state == PAD) ? PAD_SYM : core_sym;
    last_step = 1'b0;
    frame_end = 1'b0;
    case (state)
      DATA: begin
        last_step = (bit_cnt == 3'd7);
        frame_end = last_step && eof_q && !TAIL_EN;
      end
      TAIL: begin
        last_step = (bit_cnt == TAIL_LAST);
        frame_end = last_step && byte_done;
      end
      PAD: begin
        last_step = byte_done;
        frame_end = byte_done;
      end
      default: ;
    endcase
  end

  conv_enc_core #(.K(K)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept && in_sof),
    .adv     (adv && encoding),
    .bit_in  (enc_bit),
    .sym_out (core_sym)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: data bits, then optional tail, then pad to a byte edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = DATA;
      DATA: if (adv && last_step) state_nxt = (eof_q && TAIL_EN) ? TAIL : IDLE;
      TAIL: if (adv && last_step) state_nxt = byte_done ? IDLE : PAD;
      PAD:  if (adv && last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Input byte shifter and bit counter; the counter is reused for tail bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      eof_q   <= 1'b0;
    end else if (accept) begin
      shreg   <= in_data;
      bit_cnt <= '0;
      eof_q   <= in_eof;
    end else if (adv && encoding) begin
      shreg   <= {1'b0, shreg[7:1]};
      bit_cnt <= (state == TAIL && last_step) ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  // Packer: collect three symbols, emit the byte with the fourth. A load on
  // the same edge as a consume wins, so back-to-back bytes have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt   <= '0;
      pack      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (adv) begin
        sym_cnt <= sym_cnt + 2'd1;
        if (byte_done) begin
          out_data  <= {sym, pack};
          out_valid <= 1'b1;
          out_last  <= frame_end;
        end else begin
          pack <= {sym, pack[PACK_W-1:SYM_W]};
        end
      end
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE) || out_valid;

endmodule

// File: doc/conv_encoder_packer.md
# conv_encoder_packer

Rate-1/2 convolutional encoder that turns data bytes into packed 2-bit symbol bytes, four symbols per byte, in the exact format the Viterbi decoder's byte interface consumes. It is the transmit-side counterpart of the decoder. It drives decoder test traffic on-chip (loopback) and can be used as a standalone encoder. Constraint length and generator polynomials match the decoder build: K=3 (7,5), K=5 (23,35), K=7 (171,133 octal).

## Interface
- `K`, default 5: constraint length. Legal values are 3, 5, 7; any other value is an elaboration error.
- `TAIL_EN`, default 1: when 1, K-1 zero tail bits are appended after a byte flagged `in_eof`.
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_data`, in, 8: data byte, transmitted LSB first.
- `in_sof`, in, 1: sampled with the byte; clears encoder state before bit 0.
- `in_eof`, in, 1: sampled with the byte; marks the last byte of the frame.
- `in_valid`, in, 1: byte offered.
- `in_ready`, out, 1: byte accepted on an edge where `in_valid && in_ready`.
- `out_data`, out, 8: symbol byte `{s3,s2,s1,s0}`, where s0 is the oldest symbol.
- `out_valid`, out, 1: `out_data` holds a byte.
- `out_ready`, in, 1: byte consumed on an edge where `out_valid && out_ready`.
- `out_last`, out, 1: qualifies `out_data`; set on the final byte of a frame.
- `busy`, out, 1: high when not in IDLE or when `out_valid` is high.

## Operation
- **Encoder register.** `st` is K-1 bits. For each input bit b:
  - Form `r = {st, b}`; b is the LSB.
  - Symbol bit 1 is `^(r & G0)`; symbol bit 0 is `^(r & G1)`.
  - Update `st <= {st[K-3:0], b}`.
- **Generator masks:**
  - K=3: G0 = 3'b111, G1 = 3'b101.
  - K=5: G0 = 5'b10011, G1 = 5'b11101.
  - K=7: G0 = 7'b1111001, G1 = 7'b1011011.
- **FSM states:** IDLE, DATA, TAIL, PAD.
  - IDLE: `in_ready = 1`. On acceptance:
    - Load the byte into the shift register and clear the bit counter.
    - Latch `eof`.
    - If `in_sof`, set `st` to 0.
    - Go to DATA.
  - DATA: encode one bit per advancing cycle, 8 cycles.
    - After bit 7, if `eof && TAIL_EN`, go to TAIL.
    - Otherwise go to IDLE. Reaching IDLE here means `out_last = eof` on the second byte.
  - TAIL: encode K-1 zero bits.
    - If the symbol count mod 4 is then nonzero, go to PAD; otherwise go to IDLE.
    - `st` ends at 0.
  - PAD: insert `2'b00` symbols until the byte completes, then go to IDLE.
  - A TAIL/PAD frame emits the following bytes; the final one carries `out_last = 1`:
    - K=3: 1 extra byte (2 tail symbols + 2 pad).
    - K=5: 1 extra byte (4 tail symbols).
    - K=7: 2 extra bytes (6 tail symbols + 2 pad).
- **Packer.**
  - A 2-bit symbol counter and a 6-bit pack register collect symbols.
  - On the edge that produces symbol 3, `out_data <= {sym, pack}` and `out_valid <= 1`.
  - If the output register is occupied and not being consumed on that edge, the FSM stalls with no state change and no symbol is produced.
- **Simultaneous events.**
  - `in_sof` and `in_eof` may both be set on the same byte.
  - A load into `out_data` and a consume on the same edge counts as a load (no bubble).
  - `in_valid` outside IDLE is ignored.

## Timing
- **Reset values:**
  - `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_last = 0`, `busy = 0`.
  - `st = 0`; FSM in IDLE.
  - Reset mid-frame discards everything immediately, asynchronously.
- **Latency.** With byte accepted at edge 0:
  - First symbol byte is valid after edge 4.
  - Second symbol byte is valid after edge 8, provided the first was consumed by edge 8.
  - FSM is back in IDLE after edge 8.
- **Throughput.** Sustained rate is 9 cycles per data byte with `out_ready` held at 1.
- **Stall behaviour.** `out_data` and `out_last` are held stable while `out_valid && !out_ready`.

## Structure
- Shared package `viterbi_pkg` holds:
  - Generator masks G0/G1 per K, as functions of K.
  - The `state_t` enum.
  - Symbol-packing order constants.
  - The decoder uses the same masks from this package.
- Natural sub-module: `conv_enc_core`. It holds `st` and computes the combinational symbol, with ports `clk`, `rst`, `clr`, `adv`, `bit_in`, `sym_out`. The packer and FSM stay in the top module.

## Test plan
- K=3, byte 0x01 with sof, `out_ready` = 1 → bytes 0x3B then 0x00. With `TAIL_EN = 0`, no further output.
- K=5, byte 0x01 with sof → bytes 0x5B, 0x03; first byte appears 4 cycles after acceptance.
- K=3, `TAIL_EN = 1`, byte 0x80 with sof+eof → bytes 0x00, 0xC0, 0x0E; `out_last` is set only on 0x0E.
- K=7 tail on an eof byte → exactly 4 output bytes, the last with the top two symbols equal to 00. `st` is 0 after the frame.
- Stall: hold `out_ready` at 0 for 20 cycles after the first byte → `out_data` stays stable, `in_ready` stays 0, no symbols are lost. On release, the next byte is 0x00, as in the K=3 0x01 case.
- Assert `rst` mid-DATA → `out_valid` is 0 at once, `in_ready` is 1. A following sof frame encodes identically to the same frame sent after a fresh reset. Loopback through the decoder recovers 0xB4 and a 16-bit pattern with zero errors.
